// File: rtl/spi_master_multi.sv
// SPI master: one BITS-wide full-duplex frame per start, all four CPOL/CPHA modes,
// NSS active-low selects and an optional clr pulse ahead of the frame.
module spi_master_multi #(
   parameter int BITS    = 8,
   parameter int DIV     = 25000,
   parameter int SETUP   = 25000,
   parameter int CLR_CYC = 25000,
   parameter int NSS     = 1
)(
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                start,
   input  logic                                clr_ctrl,
   input  logic [1:0]                          mode,
   input  logic [((NSS>1)?$clog2(NSS):1)-1:0]  ss_sel,
   input  logic [BITS-1:0]                     data2trans,
   input  logic                                miso,
   output logic                                busy,
   output logic                                done,
   output logic                                clr,
   output logic [NSS-1:0]                      ss_n,
   output logic                                sclk,
   output logic                                mosi,
   output logic [BITS-1:0]                     data_rec
);
   localparam int SSW  = (NSS > 1) ? $clog2(NSS) : 1;
   localparam int HW   = $clog2(DIV);
   localparam int EW   = $clog2(2*BITS);
   localparam int PMAX = (SETUP > CLR_CYC) ? SETUP : CLR_CYC;
   localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;

   typedef enum logic [2:0] {S_IDLE, S_SHDOWN, S_SETUP, S_XFER, S_HOLD} state_t;

   state_t          state, state_nx;
   logic [HW-1:0]   hcnt;
   logic [PW-1:0]   pcnt;
   logic [EW-1:0]   ecnt;
   logic [1:0]      mode_q;
   logic [SSW-1:0]  sel_q;
   logic [BITS-1:0] tx_q, rx_q;
   logic            accept, hp_end, last_edge, act, lead, do_sample, do_shift;

   assign accept    = (state == S_IDLE) && start;
   assign hp_end    = (hcnt == HW'(DIV-1));
   assign last_edge = (ecnt == EW'(2*BITS-1));
   assign busy      = (state != S_IDLE);
   assign clr       = (state == S_SHDOWN);
   assign act       = (state == S_SETUP) || (state == S_XFER) || (state == S_HOLD);
   assign mosi      = tx_q[BITS-1];

   // ecnt even means the upcoming toggle is a leading edge
   assign lead      = ~ecnt[0];
   assign do_sample = mode_q[0] ? ~lead : lead;
   assign do_shift  = mode_q[0] ? (lead && (ecnt != '0)) : ~lead;

   always_comb begin
      ss_n = '1;
      for (int i = 0; i < NSS; i++)
         if (act && (sel_q == SSW'(i))) ss_n[i] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (start) state_nx = clr_ctrl ? S_SHDOWN : S_SETUP;
         S_SHDOWN: if (pcnt == PW'(CLR_CYC-1)) state_nx = S_SETUP;
         S_SETUP:  if (pcnt == PW'(SETUP-1)) state_nx = S_XFER;
         S_XFER:   if (hp_end && last_edge) state_nx = S_HOLD;
         S_HOLD:   if (hp_end) state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcnt     <= '0;
         pcnt     <= '0;
         ecnt     <= '0;
         mode_q   <= '0;
         sel_q    <= '0;
         tx_q     <= '0;
         rx_q     <= '0;
         sclk     <= 1'b0;
         done     <= 1'b0;
         data_rec <= '0;
      end else begin
         done <= 1'b0;
         // pcnt times both the clr pulse and the select setup, restarting on each state change
         if (state_nx != state)                               pcnt <= '0;
         else if ((state == S_SHDOWN) || (state == S_SETUP))  pcnt <= pcnt + 1'b1;

         if ((state == S_XFER) || (state == S_HOLD)) hcnt <= hp_end ? '0 : hcnt + 1'b1;
         else                                        hcnt <= '0;

         if (accept) begin
            mode_q <= mode;
            sel_q  <= ss_sel;
            tx_q   <= data2trans;
            rx_q   <= '0;
            sclk   <= mode[1];
         end else if (state == S_IDLE) begin
            sclk   <= mode_q[1];
         end

         if (state == S_XFER && hp_end) begin
            sclk <= ~sclk;
            ecnt <= last_edge ? '0 : ecnt + 1'b1;
            if (do_sample) rx_q <= {rx_q[BITS-2:0], miso};
            if (do_shift)  tx_q <= {tx_q[BITS-2:0], 1'b0};
         end else if (state != S_XFER) begin
            ecnt <= '0;
         end

         if (state == S_HOLD && hp_end) begin
            done     <= 1'b1;
            data_rec <= rx_q;
         end
      end
   end
endmodule
